// File: rtl/pe_row_if.sv
// Bus bundle for one pe_row: control strobes, activation stream, weight and partial-sum buses.
// The DUT connects through the slave modport; whatever drives the row uses master.
interface pe_row_if #(
  parameter int COLS   = 8,
  parameter int DATA_W = 16,
  parameter int SUM_W  = 32
);
  logic                   en;
  logic                   w_load;
  logic                   w_swap;
  logic                   ovf_clr;
  logic [DATA_W-1:0]      act_in;
  logic                   act_valid_in;
  logic [DATA_W-1:0]      act_out;
  logic                   act_valid_out;
  logic [COLS*DATA_W-1:0] w_in;
  logic [COLS*DATA_W-1:0] w_out;
  logic [COLS*SUM_W-1:0]  sum_in;
  logic [COLS*SUM_W-1:0]  sum_out;
  logic [COLS-1:0]        sum_valid_out;
  logic [COLS-1:0]        ovf;

  modport master (
    output en, w_load, w_swap, ovf_clr, act_in, act_valid_in, w_in, sum_in,
    input  act_out, act_valid_out, w_out, sum_out, sum_valid_out, ovf
  );

  modport slave (
    input  en, w_load, w_swap, ovf_clr, act_in, act_valid_in, w_in, sum_in,
    output act_out, act_valid_out, w_out, sum_out, sum_valid_out, ovf
  );
endinterface

// File: rtl/pe_row.sv
// Weight-stationary systolic PE row: activations shift right one column per cycle, each column
// MACs against its active weight and adds to the partial sum from above, optionally saturating.
module pe_row #(
  parameter int COLS   = 8,
  parameter int DATA_W = 16,
  parameter int SUM_W  = 32,
  parameter int SAT    = 1
) (
  input logic     clk,
  input logic     reset,
  pe_row_if.slave bus
);
  localparam int PROD_W = 2 * DATA_W;
  localparam logic signed [SUM_W-1:0] SUM_MAX = {1'b0, {(SUM_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN = {1'b1, {(SUM_W-1){1'b0}}};

  // The guard-bit sum overflowed SUM_W iff its top two bits disagree.
  function automatic logic sum_overflowed(input logic signed [SUM_W:0] s);
    return s[SUM_W] != s[SUM_W-1];
  endfunction

  function automatic logic signed [SUM_W-1:0] sum_saturate(input logic signed [SUM_W:0] s);
    if (!sum_overflowed(s)) return s[SUM_W-1:0];
    return s[SUM_W] ? SUM_MIN : SUM_MAX;
  endfunction

  logic signed [DATA_W-1:0] act_p0   [COLS];
  logic        [COLS-1:0]   vld_p0;
  logic signed [DATA_W-1:0] w_shadow [COLS];
  logic signed [DATA_W-1:0] w_active [COLS];
  logic signed [SUM_W-1:0]  sum_p1   [COLS];
  logic        [COLS-1:0]   vld_p1;
  logic        [COLS-1:0]   ovf_q;

  logic signed [DATA_W-1:0] col_act    [COLS];
  logic        [COLS-1:0]   col_vld;
  logic signed [SUM_W-1:0]  col_sum_in [COLS];
  logic signed [SUM_W-1:0]  mac_res    [COLS];
  logic        [COLS-1:0]   ovf_set;

  // Column inputs: column 0 sees the row input directly, column c sees column c-1's register.
  always_comb begin
    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W:0]    sum_ext;
    prod    = '0;
    sum_ext = '0;
    col_vld = '0;
    ovf_set = '0;
    col_act[0] = bus.act_in;
    col_vld[0] = bus.act_valid_in;
    for (int c = 1; c < COLS; c++) begin
      col_act[c] = act_p0[c-1];
      col_vld[c] = vld_p0[c-1];
    end
    for (int c = 0; c < COLS; c++) begin
      col_sum_in[c] = bus.sum_in[c*SUM_W +: SUM_W];
      prod          = PROD_W'(col_act[c]) * PROD_W'(w_active[c]);
      sum_ext       = {col_sum_in[c][SUM_W-1], col_sum_in[c]}
                    + {{(SUM_W+1-PROD_W){prod[PROD_W-1]}}, prod};
      mac_res[c]    = (SAT != 0) ? sum_saturate(sum_ext) : sum_ext[SUM_W-1:0];
      ovf_set[c]    = (SAT != 0) && col_vld[c] && sum_overflowed(sum_ext);
    end
  end

  // Stage p0 (activation pipe, weights) and p1 (partial sums, flags) share one register bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < COLS; c++) begin
        act_p0[c]   <= '0;
        w_shadow[c] <= '0;
        w_active[c] <= '0;
        sum_p1[c]   <= '0;
      end
      vld_p0 <= '0;
      vld_p1 <= '0;
      ovf_q  <= '0;
    end else if (bus.en) begin
      vld_p0 <= col_vld;
      vld_p1 <= col_vld;
      for (int c = 0; c < COLS; c++) begin
        act_p0[c] <= col_act[c];
        sum_p1[c] <= col_vld[c] ? mac_res[c] : col_sum_in[c];
        if (bus.w_load) w_shadow[c] <= bus.w_in[c*DATA_W +: DATA_W];
        // Swap reads the shadow before this cycle's load lands.
        if (bus.w_swap) w_active[c] <= w_shadow[c];
        if (ovf_set[c])       ovf_q[c] <= 1'b1;
        else if (bus.ovf_clr) ovf_q[c] <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.w_out   = '0;
    bus.sum_out = '0;
    for (int c = 0; c < COLS; c++) begin
      bus.w_out[c*DATA_W +: DATA_W] = w_shadow[c];
      bus.sum_out[c*SUM_W +: SUM_W] = sum_p1[c];
    end
  end

  assign bus.act_out       = act_p0[COLS-1];
  assign bus.act_valid_out = vld_p0[COLS-1];
  assign bus.sum_valid_out = vld_p1;
  assign bus.ovf           = ovf_q;
endmodule

// File: tb/tb_pe_row.sv
// Scoreboard bench for pe_row: one stimulus stream drives a saturating and a wrapping row; a
// delay-line reference model predicts every cycle's outputs and a monitor compares them.
module tb_pe_row;
  localparam int COLS   = 4;
  localparam int DATA_W = 16;
  localparam int SUM_W  = 32;
  localparam int CW     = 2 * COLS * SUM_W;
  localparam longint SUM_MAX = (longint'(1) << (SUM_W-1)) - 1;
  localparam longint SUM_MIN = -(longint'(1) << (SUM_W-1));

  typedef struct {
    logic [COLS*SUM_W-1:0]  sum;
    logic [COLS-1:0]        sv;
    logic [DATA_W-1:0]      act;
    logic                   av;
    logic [COLS-1:0]        ovf;
    logic [COLS*DATA_W-1:0] w;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0, w_load = 1'b0, w_swap = 1'b0, ovf_clr = 1'b0, act_valid_in = 1'b0;
  logic [DATA_W-1:0]      act_in = '0;
  logic [COLS*DATA_W-1:0] w_in   = '0;
  logic [COLS*SUM_W-1:0]  sum_in = '0;
  int checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;

  pe_row_if #(.COLS(COLS), .DATA_W(DATA_W), .SUM_W(SUM_W)) bus_s ();
  pe_row_if #(.COLS(COLS), .DATA_W(DATA_W), .SUM_W(SUM_W)) bus_w ();

  assign bus_s.en = en;           assign bus_w.en = en;
  assign bus_s.w_load = w_load;   assign bus_w.w_load = w_load;
  assign bus_s.w_swap = w_swap;   assign bus_w.w_swap = w_swap;
  assign bus_s.ovf_clr = ovf_clr; assign bus_w.ovf_clr = ovf_clr;
  assign bus_s.act_in = act_in;   assign bus_w.act_in = act_in;
  assign bus_s.act_valid_in = act_valid_in; assign bus_w.act_valid_in = act_valid_in;
  assign bus_s.w_in = w_in;       assign bus_w.w_in = w_in;
  assign bus_s.sum_in = sum_in;   assign bus_w.sum_in = sum_in;

  pe_row #(.COLS(COLS), .DATA_W(DATA_W), .SUM_W(SUM_W), .SAT(1)) dut_s (
    .clk(clk), .reset(reset), .bus(bus_s.slave));
  pe_row #(.COLS(COLS), .DATA_W(DATA_W), .SUM_W(SUM_W), .SAT(0)) dut_w (
    .clk(clk), .reset(reset), .bus(bus_w.slave));

  // Reference model: ahist[d] is the activation offered d enabled cycles ago (d=0 is now),
  // which is exactly what column d consumes this cycle.
  int   ahist[$];
  bit   vhist[$];
  int   ws_m[COLS];
  int   wa_m[COLS];
  exp_t cur[2];
  exp_t q_s[$];
  exp_t q_w[$];

  function automatic void model_reset();
    ahist.delete();
    vhist.delete();
    for (int c = 0; c < COLS; c++) begin
      ahist.push_back(0);
      vhist.push_back(1'b0);
      ws_m[c] = 0;
      wa_m[c] = 0;
    end
    for (int k = 0; k < 2; k++) cur[k] = '{default: '0};
    q_s.delete();
    q_w.delete();
  endfunction

  function automatic void model_step();
    longint sin, s;
    bit     set;
    int     tmp;
    bit     tb;
    if (en) begin
      ahist.push_front(int'($signed(act_in)));
      vhist.push_front(act_valid_in);
      tmp = ahist.pop_back();
      tb  = vhist.pop_back();
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < COLS; c++) begin
          sin = longint'($signed(sum_in[c*SUM_W +: SUM_W]));
          set = 1'b0;
          if (vhist[c]) begin
            s = sin + longint'(ahist[c]) * longint'(wa_m[c]);
            if (k == 0 && s > SUM_MAX) begin s = SUM_MAX; set = 1'b1; end
            else if (k == 0 && s < SUM_MIN) begin s = SUM_MIN; set = 1'b1; end
            cur[k].sum[c*SUM_W +: SUM_W] = s[SUM_W-1:0];
            cur[k].sv[c] = 1'b1;
          end else begin
            cur[k].sum[c*SUM_W +: SUM_W] = sin[SUM_W-1:0];
            cur[k].sv[c] = 1'b0;
          end
          if (set) cur[k].ovf[c] = 1'b1;
          else if (ovf_clr) cur[k].ovf[c] = 1'b0;
        end
        tmp = ahist[COLS-1];
        cur[k].act = tmp[DATA_W-1:0];
        cur[k].av  = vhist[COLS-1];
      end
      for (int c = 0; c < COLS; c++) begin
        if (w_swap) wa_m[c] = ws_m[c];
        if (w_load) ws_m[c] = int'($signed(w_in[c*DATA_W +: DATA_W]));
      end
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < COLS; c++) cur[k].w[c*DATA_W +: DATA_W] = ws_m[c][DATA_W-1:0];
    end
    q_s.push_back(cur[0]);
    q_w.push_back(cur[1]);
  endfunction

  function automatic void cmp(string nm, logic [CW-1:0] got, logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, exp);
    end
  endfunction

  function automatic void check_out(string tag, exp_t e, logic [COLS*SUM_W-1:0] sum,
                                    logic [COLS-1:0] sv, logic [DATA_W-1:0] act, logic av,
                                    logic [COLS-1:0] ovf, logic [COLS*DATA_W-1:0] w);
    cmp({tag, ".sum_out"}, CW'(sum), CW'(e.sum));
    cmp({tag, ".sum_valid_out"}, CW'(sv), CW'(e.sv));
    cmp({tag, ".act_out"}, CW'({av, act}), CW'({e.av, e.act}));
    cmp({tag, ".ovf"}, CW'(ovf), CW'(e.ovf));
    cmp({tag, ".w_out"}, CW'(w), CW'(e.w));
  endfunction

  function automatic void check_zero(string nm);
    cmp({nm, ".sum_out"}, {bus_s.sum_out, bus_w.sum_out}, '0);
    cmp({nm, ".act_out"}, CW'({bus_s.act_valid_out, bus_s.act_out, bus_w.act_valid_out, bus_w.act_out}), '0);
    cmp({nm, ".w_out"}, CW'({bus_s.w_out, bus_w.w_out}), '0);
    cmp({nm, ".flags"}, CW'({bus_s.sum_valid_out, bus_s.ovf, bus_w.sum_valid_out, bus_w.ovf}), '0);
  endfunction

  // Monitor: each queued expectation describes the outputs after the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_s.size() > 0) begin
        e = q_s.pop_front();
        check_out("sat", e, bus_s.sum_out, bus_s.sum_valid_out, bus_s.act_out,
                  bus_s.act_valid_out, bus_s.ovf, bus_s.w_out);
      end
      if (q_w.size() > 0) begin
        e = q_w.pop_front();
        check_out("wrap", e, bus_w.sum_out, bus_w.sum_valid_out, bus_w.act_out,
                  bus_w.act_valid_out, bus_w.ovf, bus_w.w_out);
      end
    end
  end

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [COLS*DATA_W-1:0] wvec(int a, int b, int c, int d);
    return {DATA_W'(d), DATA_W'(c), DATA_W'(b), DATA_W'(a)};
  endfunction

  function automatic logic [DATA_W-1:0] rnd_d();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      default: return DATA_W'($urandom);
    endcase
  endfunction

  function automatic logic [SUM_W-1:0] rnd_s();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return SUM_W'($urandom_range(0, 255));
      default: return SUM_W'($urandom);
    endcase
  endfunction

  task automatic mid_reset();
    #2;
    reset = 1'b0;
    #1;
    check_zero("rst_mid");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst_hold");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (2) step();

    // Basic MAC: weights 1..4, one activation of 6
    w_in = wvec(1, 2, 3, 4); w_load = 1'b1; step();
    w_load = 1'b0; w_swap = 1'b1; step();
    w_swap = 1'b0;
    act_in = 16'd6; act_valid_in = 1'b1; step();
    act_valid_in = 1'b0; act_in = '0; repeat (5) step();

    // Double buffer under a continuous stream of 7
    act_in = 16'd7; act_valid_in = 1'b1; repeat (4) step();
    w_in = wvec(2, 2, 2, 2); w_load = 1'b1; step();
    w_load = 1'b0; repeat (3) step();
    w_swap = 1'b1; step();
    w_swap = 1'b0; repeat (4) step();
    w_in = wvec(5, 5, 5, 5); w_load = 1'b1; w_swap = 1'b1; step();
    w_load = 1'b0; w_swap = 1'b0; repeat (4) step();

    // Saturation at both rails, then clear, then clear colliding with a new overflow
    act_valid_in = 1'b0;
    w_in = wvec(32767, 32767, 32767, 32767); w_load = 1'b1; step();
    w_load = 1'b0; w_swap = 1'b1; step();
    w_swap = 1'b0;
    for (int i = 0; i < 6; i++) begin
      act_in       = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
      sum_in       = (i % 2 == 0) ? {COLS{32'h7FFF_FFFF}} : {COLS{32'h8000_0000}};
      act_valid_in = (i < 2);
      step();
    end
    ovf_clr = 1'b1; step();
    ovf_clr = 1'b0; step();
    act_in = 16'h7FFF; act_valid_in = 1'b1; sum_in = {COLS{32'h7FFF_FFFF}}; ovf_clr = 1'b1; step();
    ovf_clr = 1'b0; act_valid_in = 1'b0; repeat (4) step();

    // Bubbles carry sum_in straight through
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < COLS; c++) sum_in[c*SUM_W +: SUM_W] = rnd_s();
      sum_in[1*SUM_W +: SUM_W] = 32'h0000_1234;
      step();
    end

    // Enable drop for three cycles in the middle of a valid stream
    w_in = wvec(3, -4, 5, -6); w_load = 1'b1; w_swap = 1'b1; step();
    w_swap = 1'b1; w_load = 1'b0; step();
    w_swap = 1'b0;
    for (int i = 0; i < 12; i++) begin
      act_in = rnd_d(); act_valid_in = 1'b1;
      sum_in = {COLS{SUM_W'(i * 100)}};
      en = !(i >= 4 && i < 7);
      w_load = (i == 5); ovf_clr = (i == 6);
      step();
    end
    en = 1'b1; w_load = 1'b0; ovf_clr = 1'b0;

    // Randomised traffic with a mid-stream reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) mid_reset();
      en           = ($urandom_range(0, 9) != 0);
      w_load       = ($urandom_range(0, 4) == 0);
      w_swap       = ($urandom_range(0, 6) == 0);
      ovf_clr      = ($urandom_range(0, 9) == 0);
      act_valid_in = ($urandom_range(0, 9) < 7);
      act_in       = rnd_d();
      for (int c = 0; c < COLS; c++) begin
        w_in[c*DATA_W +: DATA_W]  = rnd_d();
        sum_in[c*SUM_W +: SUM_W] = rnd_s();
      end
      step();
    end
    en = 1'b1; w_load = 1'b0; w_swap = 1'b0; ovf_clr = 1'b0; act_valid_in = 1'b0;
    repeat (3) step();
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
